// File: rtl/fht_pkg.sv
// -----------------------------------------------------------------------------
// fht_pkg
// Shared definitions for the FHT memory subsystem:
//   - default address / sample widths of the bank RAMs
//   - bank count and bank-index width
//   - arbiter FSM state encoding
//   - RUN watchdog length and drain-window length helper
//   - one-hot bank decode helper
// -----------------------------------------------------------------------------
package fht_pkg;

    localparam int FHT_A_BIT          = 8;   // per-bank word address width
    localparam int FHT_D_BIT          = 16;  // sample width
    localparam int FHT_NUM_BANKS      = 4;
    localparam int FHT_BANK_BIT       = $clog2(FHT_NUM_BANKS);

    // Cycles after the start pulse within which RDY must drop, otherwise the
    // pass is considered already finished.
    localparam int FHT_TIMEOUT_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOST_WR = 3'd1,
        ST_HOST_RD = 3'd2,
        ST_START   = 3'd3,
        ST_RUN     = 3'd4,
        ST_DRAIN   = 3'd5
    } fht_arb_state_t;

    // Length of the window (in clocks) during which the banks stay with the
    // FHT after the end of a pass is detected, so the last writes issued
    // through a RAM with the given read latency can retire.
    function automatic int fht_drain_len(input int rd_lat);
        return rd_lat + 1;
    endfunction

    function automatic logic [FHT_NUM_BANKS-1:0] fht_bank_onehot(
        input logic [FHT_BANK_BIT-1:0] bank
    );
        logic [FHT_NUM_BANKS-1:0] oh;
        oh       = '0;
        oh[bank] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/fht_arb_rd_pipe.sv
// -----------------------------------------------------------------------------
// fht_arb_rd_pipe
// RD_LAT-deep shift register that follows a host read through the bank RAM
// pipeline. A read issued in cycle t appears at the output in cycle t+RD_LAT,
// together with the bank it was addressed to, aligned with the RAM data.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset; flushes in-flight reads
//   in_valid  in   read issued this cycle
//   in_bank   in   bank number of the issued read
//   out_valid out  read data is present on the bank outputs this cycle
//   out_bank  out  bank whose data must be selected
// -----------------------------------------------------------------------------
module fht_arb_rd_pipe
    import fht_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [FHT_BANK_BIT-1:0] in_bank,
    output logic                    out_valid,
    output logic [FHT_BANK_BIT-1:0] out_bank
);

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
            logic                    valid_reg;
            logic [FHT_BANK_BIT-1:0] bank_reg;

            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        valid_reg <= 1'b0;
                        bank_reg  <= '0;
                    end else begin
                        valid_reg <= in_valid;
                        bank_reg  <= in_bank;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        valid_reg <= 1'b0;
                        bank_reg  <= '0;
                    end else begin
                        valid_reg <= g_stage[gi-1].valid_reg;
                        bank_reg  <= g_stage[gi-1].bank_reg;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[RD_LAT-1].valid_reg;
    assign out_bank  = g_stage[RD_LAT-1].bank_reg;

endmodule

// File: rtl/fht_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fht_mem_arbiter
// Arbitrates the four FHT sample banks between the host and fht_control.
// The host gets single read/write accesses while idle; a run request hands
// the banks to the FHT until its pass completes (RDY falls then rises, or
// RDY never falls within the watchdog window) plus a short drain window.
//
// Optional feature (macro FHT_ARB_STAT_EN): oRUN_CYCLES, a saturating count
// of RUN/DRAIN cycles of the most recent pass.
//
// Parameters: A_BIT (word address width), D_BIT (sample width),
//             RD_LAT (bank RAM read latency, 1..3).
// Ports:
//   iCLK, iRESET          clock; asynchronous active-high reset
//   iHOST_REQ/WE/ADDR/DATA host request ({bank, word} address), held until
//                         granted
//   oHOST_GNT             one-cycle acceptance
//   oHOST_DATA/VALID      host read data, one-cycle valid
//   iRUN_REQ              pulse requesting one FHT pass
//   oSTART                start pulse to fht_control
//   iFHT_RDY              fht_control ready (low while transforming)
//   oBUSY                 FHT owns the banks
//   oHOST_SEL             bank mux select, 1 = host side
//   oHOST_WE_BANK         one-hot host write enable
//   oHOST_RAM_ADDR        host word address to the banks
//   oHOST_RAM_WDATA       host write data, aligned with oHOST_WE_BANK
//   iBANK_RDATA           read data of all banks, bank b at [b*D_BIT +: D_BIT]
//   oRUN_CYCLES           (FHT_ARB_STAT_EN only) pass length statistic
// -----------------------------------------------------------------------------
module fht_mem_arbiter
    import fht_pkg::*;
#(
    parameter int A_BIT  = FHT_A_BIT,
    parameter int D_BIT  = FHT_D_BIT,
    parameter int RD_LAT = 2
) (
    input  logic                            iCLK,
    input  logic                            iRESET,
    input  logic                            iHOST_REQ,
    input  logic                            iHOST_WE,
    input  logic [A_BIT+FHT_BANK_BIT-1:0]   iHOST_ADDR,
    input  logic [D_BIT-1:0]                iHOST_DATA,
    output logic                            oHOST_GNT,
    output logic [D_BIT-1:0]                oHOST_DATA,
    output logic                            oHOST_VALID,
    input  logic                            iRUN_REQ,
    output logic                            oSTART,
    input  logic                            iFHT_RDY,
    output logic                            oBUSY,
    output logic                            oHOST_SEL,
    output logic [FHT_NUM_BANKS-1:0]        oHOST_WE_BANK,
    output logic [A_BIT-1:0]                oHOST_RAM_ADDR,
    output logic [D_BIT-1:0]                oHOST_RAM_WDATA,
    input  logic [FHT_NUM_BANKS*D_BIT-1:0]  iBANK_RDATA
`ifdef FHT_ARB_STAT_EN
    ,
    output logic [15:0]                     oRUN_CYCLES
`endif
);

    // The drain window counts from the cycle in which the end of the pass is
    // detected (still in RUN), so the DRAIN state itself lasts one cycle
    // less. The counter runs down to zero, hence the "-2".
    localparam logic [1:0] DRAIN_LOAD   = 2'(fht_drain_len(RD_LAT) - 2);
    // RUN cycles that may see RDY still high before the watchdog fires;
    // DRAIN is then entered FHT_TIMEOUT_CYCLES after the start pulse.
    localparam logic [1:0] TIMEOUT_LAST = 2'(FHT_TIMEOUT_CYCLES - 2);

    fht_arb_state_t state_reg, state_next;
    logic [1:0]     cnt_reg, cnt_next;
    logic           seen_low_reg, seen_low_next;
    logic [FHT_BANK_BIT-1:0] bank_reg, bank_next;

    logic                     gnt_reg, gnt_next;
    logic                     start_reg, start_next;
    logic                     busy_reg, busy_next;
    logic                     sel_reg, sel_next;
    logic [FHT_NUM_BANKS-1:0] we_bank_reg, we_bank_next;
    logic [A_BIT-1:0]         addr_reg, addr_next;
    logic [D_BIT-1:0]         wdata_reg, wdata_next;
    logic                     valid_reg, valid_next;
    logic [D_BIT-1:0]         rdata_reg, rdata_next;

    logic [FHT_BANK_BIT-1:0]  host_bank;
    logic [A_BIT-1:0]         host_word;
    logic                     pipe_in_valid;
    logic                     pipe_out_valid;
    logic [FHT_BANK_BIT-1:0]  pipe_out_bank;
    logic [D_BIT-1:0]         bank_rdata [FHT_NUM_BANKS];

    assign host_bank = iHOST_ADDR[A_BIT +: FHT_BANK_BIT];
    assign host_word = iHOST_ADDR[A_BIT-1:0];

    generate
        for (genvar gi = 0; gi < FHT_NUM_BANKS; gi++) begin : g_bank_unpack
            assign bank_rdata[gi] = iBANK_RDATA[gi*D_BIT +: D_BIT];
        end
    endgenerate

    // A read enters the RAM pipeline in the granted cycle of HOST_RD.
    assign pipe_in_valid = (state_reg == ST_HOST_RD) && gnt_reg;

    fht_arb_rd_pipe #(
        .RD_LAT(RD_LAT)
    ) u_rd_pipe (
        .clk       (iCLK),
        .rst       (iRESET),
        .in_valid  (pipe_in_valid),
        .in_bank   (bank_reg),
        .out_valid (pipe_out_valid),
        .out_bank  (pipe_out_bank)
    );

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        seen_low_next = seen_low_reg;
        bank_next     = bank_reg;
        gnt_next      = 1'b0;
        start_next    = 1'b0;
        busy_next     = busy_reg;
        sel_next      = sel_reg;
        we_bank_next  = '0;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        valid_next    = 1'b0;
        rdata_next    = rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (iRUN_REQ) begin
                    state_next    = ST_START;
                    start_next    = 1'b1;
                    sel_next      = 1'b0;
                    busy_next     = 1'b1;
                    cnt_next      = '0;
                    seen_low_next = 1'b0;
                end else if (iHOST_REQ) begin
                    gnt_next  = 1'b1;
                    addr_next = host_word;
                    bank_next = host_bank;
                    if (iHOST_WE) begin
                        state_next   = ST_HOST_WR;
                        we_bank_next = fht_bank_onehot(host_bank);
                        wdata_next   = iHOST_DATA;
                    end else begin
                        state_next = ST_HOST_RD;
                    end
                end
            end

            ST_HOST_WR: begin
                state_next = ST_IDLE;
            end

            ST_HOST_RD: begin
                if (pipe_out_valid) begin
                    state_next = ST_IDLE;
                    valid_next = 1'b1;
                    rdata_next = bank_rdata[pipe_out_bank];
                end
            end

            ST_START: begin
                state_next = ST_RUN;
            end

            ST_RUN: begin
                if (!seen_low_reg) begin
                    if (!iFHT_RDY) begin
                        seen_low_next = 1'b1;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_next = ST_DRAIN;
                        cnt_next   = DRAIN_LOAD;
                    end else begin
                        cnt_next = cnt_reg + 2'd1;
                    end
                end else if (iFHT_RDY) begin
                    state_next = ST_DRAIN;
                    cnt_next   = DRAIN_LOAD;
                end
            end

            ST_DRAIN: begin
                if (cnt_reg == 2'd0) begin
                    state_next = ST_IDLE;
                    sel_next   = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
                sel_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            seen_low_reg <= 1'b0;
            bank_reg     <= '0;
            gnt_reg      <= 1'b0;
            start_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            sel_reg      <= 1'b1;
            we_bank_reg  <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            valid_reg    <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            seen_low_reg <= seen_low_next;
            bank_reg     <= bank_next;
            gnt_reg      <= gnt_next;
            start_reg    <= start_next;
            busy_reg     <= busy_next;
            sel_reg      <= sel_next;
            we_bank_reg  <= we_bank_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            valid_reg    <= valid_next;
            rdata_reg    <= rdata_next;
        end
    end

    assign oHOST_GNT       = gnt_reg;
    assign oSTART          = start_reg;
    assign oBUSY           = busy_reg;
    assign oHOST_SEL       = sel_reg;
    assign oHOST_WE_BANK   = we_bank_reg;
    assign oHOST_RAM_ADDR  = addr_reg;
    assign oHOST_RAM_WDATA = wdata_reg;
    assign oHOST_VALID     = valid_reg;
    assign oHOST_DATA      = rdata_reg;

`ifdef FHT_ARB_STAT_EN
    logic [15:0] run_cycles_reg;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            run_cycles_reg <= '0;
        end else if (state_next == ST_START) begin
            run_cycles_reg <= '0;
        end else if ((state_reg == ST_RUN || state_reg == ST_DRAIN) &&
                     (run_cycles_reg != 16'hFFFF)) begin
            run_cycles_reg <= run_cycles_reg + 16'd1;
        end
    end

    assign oRUN_CYCLES = run_cycles_reg;
`endif

endmodule

// File: tb/tb_fht_mem_arbiter.sv
module tb_fht_mem_arbiter;
    import fht_pkg::*;

    localparam int A_BIT  = 8;
    localparam int D_BIT  = 16;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req, host_we, run_req;
    logic [9:0]  host_addr;
    logic [15:0] host_wdata;
    logic        gnt, host_valid, start, busy, host_sel;
    logic [15:0] host_rdata, ram_wdata;
    logic [3:0]  we_bank;
    logic [7:0]  ram_addr;
    logic [63:0] bank_rdata;
    logic        fht_rdy;
`ifdef FHT_ARB_STAT_EN
    logic [15:0] run_cycles;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    fht_mem_arbiter #(.A_BIT(A_BIT), .D_BIT(D_BIT), .RD_LAT(RD_LAT)) dut (
        .iCLK            (clk),
        .iRESET          (rst),
        .iHOST_REQ       (host_req),
        .iHOST_WE        (host_we),
        .iHOST_ADDR      (host_addr),
        .iHOST_DATA      (host_wdata),
        .oHOST_GNT       (gnt),
        .oHOST_DATA      (host_rdata),
        .oHOST_VALID     (host_valid),
        .iRUN_REQ        (run_req),
        .oSTART          (start),
        .iFHT_RDY        (fht_rdy),
        .oBUSY           (busy),
        .oHOST_SEL       (host_sel),
        .oHOST_WE_BANK   (we_bank),
        .oHOST_RAM_ADDR  (ram_addr),
        .oHOST_RAM_WDATA (ram_wdata),
        .iBANK_RDATA     (bank_rdata)
`ifdef FHT_ARB_STAT_EN
        ,
        .oRUN_CYCLES     (run_cycles)
`endif
    );

    // Four bank RAMs, read latency 2 (address registered, data registered).
    logic [15:0] mem [4][256];
    logic [15:0] rd_s1 [4];
    logic [15:0] rd_s2 [4];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_bank[b]) mem[b][ram_addr] <= ram_wdata;
            rd_s1[b] <= mem[b][ram_addr];
            rd_s2[b] <= rd_s1[b];
        end
    end
    assign bank_rdata = {rd_s2[3], rd_s2[2], rd_s2[1], rd_s2[0]};

    // fht_control stand-in: RDY falls 2 cycles after START, stays low 5 cycles.
    logic       fht_en;
    logic [1:0] fht_phase;
    int         fht_low;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fht_rdy   <= 1'b1;
            fht_phase <= 2'd0;
            fht_low   <= 0;
        end else if (fht_en) begin
            if (start) begin
                fht_phase <= 2'd1;
            end else if (fht_phase == 2'd1) begin
                fht_rdy   <= 1'b0;
                fht_phase <= 2'd2;
                fht_low   <= 0;
            end else if (fht_phase == 2'd2) begin
                if (fht_low == 4) begin
                    fht_rdy   <= 1'b1;
                    fht_phase <= 2'd0;
                end else begin
                    fht_low <= fht_low + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_sel"},   32'(host_sel),   32'd1);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_start"}, 32'(start),      32'd0);
        chk({tag, "_gnt"},   32'(gnt),        32'd0);
        chk({tag, "_valid"}, 32'(host_valid), 32'd0);
        chk({tag, "_webank"},32'(we_bank),    32'd0);
        chk({tag, "_addr"},  32'(ram_addr),   32'd0);
        chk({tag, "_rdata"}, 32'(host_rdata), 32'd0);
    endtask

    task automatic host_write(input logic [1:0] bank, input logic [7:0] word, input logic [15:0] data);
        logic [3:0] exp_we;
        exp_we      = 4'b0001 << bank;
        host_req    = 1'b1;
        host_we     = 1'b1;
        host_addr   = {bank, word};
        host_wdata  = data;
        step();
        chk("wr_gnt",    32'(gnt),       32'd1);
        chk("wr_webank", 32'(we_bank),   32'(exp_we));
        chk("wr_addr",   32'(ram_addr),  32'(word));
        chk("wr_wdata",  32'(ram_wdata), 32'(data));
        host_req = 1'b0;
        host_we  = 1'b0;
        step();
        chk("wr_gnt_off",    32'(gnt),     32'd0);
        chk("wr_webank_off", 32'(we_bank), 32'd0);
        $display("txn host_write bank=%0d word=%0d data=%h", bank, word, data);
    endtask

    // GNT in cycle t, VALID exactly in cycle t+RD_LAT+1.
    task automatic host_read(input logic [1:0] bank, input logic [7:0] word, input logic [15:0] exp_data);
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = {bank, word};
        step();
        chk("rd_gnt",  32'(gnt),      32'd1);
        chk("rd_addr", 32'(ram_addr), 32'(word));
        host_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("rd_valid_t%0d", k), 32'(host_valid), (k == 3) ? 32'd1 : 32'd0);
            if (k == 1) chk("rd_gnt_off", 32'(gnt), 32'd0);
        end
        chk("rd_data", 32'(host_rdata), 32'(exp_data));
        step();
        chk("rd_valid_off", 32'(host_valid), 32'd0);
        $display("txn host_read bank=%0d word=%0d data=%h", bank, word, host_rdata);
    endtask

    initial begin
        rst = 1'b1; host_req = 1'b0; host_we = 1'b0; run_req = 1'b0;
        host_addr = '0; host_wdata = '0; fht_en = 1'b0;
        step(); step();
        chk_reset_values("reset");
        chk("reset_state", 32'(dut.state_reg), 32'(ST_IDLE));
        rst = 1'b0;
        step();
        $display("txn reset released");

        host_write(2'd2, 8'd5, 16'h1234);
        host_write(2'd3, 8'd7, 16'hABCD);
        host_read(2'd3, 8'd7, 16'hABCD);
        host_read(2'd2, 8'd5, 16'h1234);

        // Full pass with a host write requested in the same cycle as the run.
        fht_en     = 1'b1;
        run_req    = 1'b1;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = {2'd0, 8'd9};
        host_wdata = 16'h5555;
        step();
        chk("pass_start", 32'(start),    32'd1);
        chk("pass_busy0", 32'(busy),     32'd1);
        chk("pass_sel0",  32'(host_sel), 32'd0);
        chk("pass_gnt0",  32'(gnt),      32'd0);
        run_req = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("pass_busy_k%0d", k),   32'(busy),     32'd1);
            chk($sformatf("pass_sel_k%0d", k),    32'(host_sel), 32'd0);
            chk($sformatf("pass_gnt_k%0d", k),    32'(gnt),      32'd0);
            chk($sformatf("pass_start_k%0d", k),  32'(start),    32'd0);
            chk($sformatf("pass_webank_k%0d", k), 32'(we_bank),  32'd0);
            if (k == 7) chk("pass_state_run",   32'(dut.state_reg), 32'(ST_RUN));
            if (k == 8) chk("pass_state_drain", 32'(dut.state_reg), 32'(ST_DRAIN));
        end
        step();  // RDY rose at k=7; host side back RD_LAT+1 cycles later
        chk("pass_sel_back",  32'(host_sel), 32'd1);
        chk("pass_busy_off",  32'(busy),     32'd0);
        chk("pass_gnt_still", 32'(gnt),      32'd0);
        step();
        chk("pass_late_gnt",    32'(gnt),      32'd1);
        chk("pass_late_webank", 32'(we_bank),  32'd1);
        chk("pass_late_addr",   32'(ram_addr), 32'd9);
        host_req = 1'b0;
        host_we  = 1'b0;
        step();
        chk("pass_late_gnt_off", 32'(gnt), 32'd0);
        $display("txn fht_pass with pending host_write bank=0 word=9");
        host_read(2'd0, 8'd9, 16'h5555);

        // Watchdog: RDY never falls.
        fht_en  = 1'b0;
        run_req = 1'b1;
        step();
        chk("to_start", 32'(start), 32'd1);
        run_req = 1'b0;
        step();
        chk("to_start_off", 32'(start), 32'd0);
        step();
        run_req = 1'b1;  // must be ignored outside IDLE
        step();
        run_req = 1'b0;
        chk("to_state_run", 32'(dut.state_reg), 32'(ST_RUN));
        chk("to_no_restart", 32'(start), 32'd0);
        step();
        chk("to_state_drain", 32'(dut.state_reg), 32'(ST_DRAIN));
        chk("to_busy_drain",  32'(busy), 32'd1);
        step();
        chk("to_busy_drain2", 32'(busy),     32'd1);
        chk("to_sel_drain2",  32'(host_sel), 32'd0);
        step();
        chk("to_sel_back",  32'(host_sel), 32'd1);
        chk("to_busy_off",  32'(busy),     32'd0);
`ifdef FHT_ARB_STAT_EN
        chk("to_run_cycles", 32'(run_cycles), 32'd5);
`endif
        step();
        chk("to_not_queued", 32'(start), 32'd0);
        chk("to_idle", 32'(dut.state_reg), 32'(ST_IDLE));
        $display("txn fht_pass watchdog timeout");

        // Reset in the middle of a pass.
        fht_en  = 1'b1;
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        step(); step(); step();
        chk("rr_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_values("rr");
        chk("rr_state", 32'(dut.state_reg), 32'(ST_IDLE));
`ifdef FHT_ARB_STAT_EN
        chk("rr_run_cycles", 32'(run_cycles), 32'd0);
`endif
        step();
        rst = 1'b0;
        step();
        chk("rr_after_busy", 32'(busy),     32'd0);
        chk("rr_after_sel",  32'(host_sel), 32'd1);
        $display("txn reset during run");

        // Reset with a host read in flight: no VALID may follow.
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = {2'd3, 8'd7};
        step();
        chk("fl_gnt", 32'(gnt), 32'd1);
        host_req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("fl_no_valid_%0d", k), 32'(host_valid), 32'd0);
        end
        $display("txn reset discards in-flight read");

        host_read(2'd3, 8'd7, 16'hABCD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/fht_mem_arbiter.md
FHT_MEM_ARBITER -- requirements
Module: fht_mem_arbiter

Interface
REQ-001 SHALL have parameter A_BIT, default 8: per-bank RAM address width.
REQ-002 SHALL have parameter D_BIT, default 16: sample width.
REQ-003 SHALL have parameter RD_LAT, default 2: bank RAM read latency in clocks; legal values 1..3.
REQ-004 SHALL have port iCLK, in, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port iRESET, in, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port iHOST_REQ, in, 1: host access request; held until granted.
REQ-007 SHALL have port iHOST_WE, in, 1: 1 = host write, 0 = host read.
REQ-008 SHALL have port iHOST_ADDR, in, A_BIT+2: {bank[1:0], word[A_BIT-1:0]}.
REQ-009 SHALL have port iHOST_DATA, in, D_BIT: host write data.
REQ-010 SHALL have port oHOST_GNT, out, 1: one-cycle acceptance of the host request.
REQ-011 SHALL have port oHOST_DATA, out, D_BIT: host read data.
REQ-012 SHALL have port oHOST_VALID, out, 1: oHOST_DATA valid, one cycle.
REQ-013 SHALL have port iRUN_REQ, in, 1: host pulse requesting one FHT pass.
REQ-014 SHALL have port oSTART, out, 1: start pulse to fht_control.
REQ-015 SHALL have port iFHT_RDY, in, 1: fht_control oRDY; low while transforming.
REQ-016 SHALL have port oBUSY, out, 1: FHT owns the banks.
REQ-017 SHALL have port oHOST_SEL, out, 1: 1 = bank mux selects host side; 0 = FHT side.
REQ-018 SHALL have port oHOST_WE_BANK, out, 4: one-hot host write enable per bank.
REQ-019 SHALL have port oHOST_RAM_ADDR, out, A_BIT: host word address to the selected bank.

Function
REQ-020 SHALL implement FSM IDLE, HOST_WR, HOST_RD, START, RUN, DRAIN.
- IDLE: iRUN_REQ -> START; else iHOST_REQ & iHOST_WE -> HOST_WR; else iHOST_REQ -> HOST_RD.
- iRUN_REQ has priority over iHOST_REQ in the same cycle.
REQ-021 SHALL, in HOST_WR, for one cycle: assert oHOST_GNT; set oHOST_WE_BANK bit = bank; drive oHOST_RAM_ADDR = word; return to IDLE.
REQ-022 SHALL, in HOST_RD: assert oHOST_GNT in the first cycle, wait RD_LAT cycles, then pulse oHOST_VALID with the bank data selected by the registered bank number, then return to IDLE.
REQ-023 SHALL, in START: pulse oSTART for exactly one cycle, clear oHOST_SEL, set oBUSY, then enter RUN.
REQ-024 SHALL, in RUN, wait for iFHT_RDY to fall, then for iFHT_RDY to rise; on the rise, enter DRAIN.
REQ-025 SHALL, in DRAIN, hold oBUSY for RD_LAT+1 cycles so the last writes retire, then set oHOST_SEL=1, clear oBUSY and enter IDLE.
REQ-026 SHALL NOT assert oHOST_GNT in START, RUN or DRAIN; a pending iHOST_REQ stays pending.
REQ-027 SHALL ignore iRUN_REQ outside IDLE; it is not queued.
REQ-028 SHALL, if iFHT_RDY has not fallen within 4 cycles of oSTART, treat the run as complete and enter DRAIN.
REQ-029 SHALL register all outputs; oHOST_WE_BANK SHALL be zero whenever oHOST_SEL=0.

Reset
REQ-030 SHALL, on iRESET, go to IDLE immediately, mid-operation included, with these output values:
- oHOST_SEL=1.
- oBUSY, oSTART, oHOST_GNT, oHOST_VALID = 0.
- oHOST_WE_BANK = 0.
- oHOST_RAM_ADDR and oHOST_DATA = 0.
REQ-031 SHALL discard any in-flight host read on reset; no oHOST_VALID follows it.

Configuration
REQ-032 SHALL, with FHT_ARB_STAT_EN defined, add output oRUN_CYCLES (16 bits): cleared at oSTART, incremented each RUN/DRAIN cycle, saturating at 16'hFFFF, held in IDLE, reset to 0.
REQ-033 SHALL, without FHT_ARB_STAT_EN, not have port oRUN_CYCLES and its logic.

Structure
REQ-034 SHALL take the FSM state enum, the bank count (4) and the DRAIN length from a shared package fht_pkg; A_BIT and D_BIT defaults SHALL match fht_defines.
REQ-035 SHALL use one sub-module, fht_arb_rd_pipe, as the RD_LAT-deep valid/bank-select shift register.

Verification
REQ-036 SHALL cover host write: REQ, WE=1, ADDR={2'd2,8'd5}, DATA=16'h1234 -> GNT one cycle, oHOST_WE_BANK=4'b0100, oHOST_RAM_ADDR=5.
REQ-037 SHALL cover host read: read {2'd3,8'd7} with RD_LAT=2 -> oHOST_VALID exactly 3 cycles after GNT, data from bank 3.
REQ-038 SHALL cover simultaneous requests: iRUN_REQ and iHOST_REQ in the same IDLE cycle -> oSTART next cycle, no GNT until after DRAIN, then GNT.
REQ-039 SHALL cover a full pass: a real fht_control that deasserts RDY 2 cycles after start -> oBUSY high throughout, oHOST_SEL=1 RD_LAT+1 cycles after the RDY rise.
REQ-040 SHALL cover the timeout: iFHT_RDY held high after oSTART -> DRAIN entered 4 cycles after oSTART.
REQ-041 SHALL cover reset during RUN: iRESET asserted -> IDLE with the REQ-030 values; with FHT_ARB_STAT_EN, oRUN_CYCLES=0.
